// File: rtl/alu_resp_tx.sv
// UART response transmitter: sends a 32-bit ALU result (4 bytes LSB first) or an
// echo byte stream as 8N1 frames (8E1 with UART_TX_PARITY_EN defined).
// Ports: clk_i/rst_ni; res_valid_i/res_ready_o/res_data_i result handshake;
// echo_valid_i/echo_ready_o/echo_data_i/echo_last_i echo handshake; tx_o line; busy_o.
module alu_resp_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  input  logic [31:0] res_data_i,
  input  logic        echo_valid_i,
  output logic        echo_ready_o,
  input  logic [7:0]  echo_data_i,
  input  logic        echo_last_i,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    P_IDLE, P_RES, P_ECHO_SEND, P_ECHO_WAIT
  } pkt_e;

  typedef enum logic [1:0] {
    B_START, B_DATA, B_PARITY, B_STOP
  } bit_e;

  pkt_e          pkt_q, pkt_d;
  bit_e          bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   sh_q, sh_d;
  logic          last_q, last_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic [2:0]    idx_n;

  assign bit_end = (cnt_q == '0);
  assign idx_n   = idx_q + 3'd1;
  assign tx_o    = tx_q;
  assign busy_o  = (pkt_q != P_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_q  <= P_IDLE;
      bit_q  <= B_START;
      cnt_q  <= '0;
      idx_q  <= '0;
      byte_q <= '0;
      sh_q   <= '0;
      last_q <= 1'b0;
      tx_q   <= 1'b1;
    end else begin
      pkt_q  <= pkt_d;
      bit_q  <= bit_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      byte_q <= byte_d;
      sh_q   <= sh_d;
      last_q <= last_d;
      tx_q   <= tx_d;
    end
  end

  always_comb begin
    pkt_d        = pkt_q;
    bit_d        = bit_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    byte_d       = byte_q;
    sh_d         = sh_q;
    last_d       = last_q;
    tx_d         = tx_q;
    res_ready_o  = 1'b0;
    echo_ready_o = 1'b0;

    unique case (pkt_q)
      P_IDLE: begin
        res_ready_o  = 1'b1;
        echo_ready_o = !res_valid_i;
        cnt_d        = '0;
        if (res_valid_i) begin
          pkt_d  = P_RES;
          sh_d   = res_data_i;
          byte_d = 2'd0;
          bit_d  = B_START;
          cnt_d  = BIT_MAX;
          tx_d   = 1'b0;
        end else if (echo_valid_i) begin
          pkt_d  = P_ECHO_SEND;
          sh_d   = {24'b0, echo_data_i};
          last_d = echo_last_i;
          bit_d  = B_START;
          cnt_d  = BIT_MAX;
          tx_d   = 1'b0;
        end
      end

      P_ECHO_WAIT: begin
        echo_ready_o = 1'b1;
        tx_d         = 1'b1;
        if (echo_valid_i) begin
          pkt_d  = P_ECHO_SEND;
          sh_d   = {24'b0, echo_data_i};
          last_d = echo_last_i;
          bit_d  = B_START;
          cnt_d  = BIT_MAX;
          tx_d   = 1'b0;
        end
      end

      default: begin
        // Echo source may hand over the next byte in the last stop cycle
        echo_ready_o = (pkt_q == P_ECHO_SEND) && (bit_q == B_STOP)
                       && bit_end && !last_q;
        cnt_d = bit_end ? BIT_MAX : cnt_q - CW'(1);
        if (bit_end) begin
          unique case (bit_q)
            B_START: begin
              bit_d = B_DATA;
              idx_d = 3'd0;
              tx_d  = sh_q[0];
            end
            B_DATA: begin
              if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                bit_d = B_PARITY;
                tx_d  = ^sh_q[7:0];
`else
                bit_d = B_STOP;
                tx_d  = 1'b1;
`endif
              end else begin
                idx_d = idx_n;
                tx_d  = sh_q[idx_n];
              end
            end
            B_PARITY: begin
              bit_d = B_STOP;
              tx_d  = 1'b1;
            end
            B_STOP: begin
              bit_d = B_START;
              tx_d  = 1'b1;
              if (pkt_q == P_RES) begin
                if (byte_q == 2'd3) begin
                  pkt_d = P_IDLE;
                  cnt_d = '0;
                end else begin
                  byte_d = byte_q + 2'd1;
                  sh_d   = sh_q >> 8;
                  tx_d   = 1'b0;
                end
              end else if (last_q) begin
                pkt_d = P_IDLE;
                cnt_d = '0;
              end else if (echo_valid_i) begin
                sh_d   = {24'b0, echo_data_i};
                last_d = echo_last_i;
                tx_d   = 1'b0;
              end else begin
                pkt_d = P_ECHO_WAIT;
                cnt_d = '0;
              end
            end
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_alu_resp_tx.sv
// Directed bench for alu_resp_tx with CLKS_PER_BIT=4; every negedge is logged
// and frames, handshakes and busy timing are checked against hand-built values.
module tb_alu_resp_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FC = 4 * FB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] res_data = '0;
  logic        echo_valid = 1'b0;
  logic        echo_ready;
  logic [7:0]  echo_data = '0;
  logic        echo_last = 1'b0;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n = 0;

  logic tx_log [0:4095];
  logic bz_log [0:4095];
  logic er_log [0:4095];
  logic rr_log [0:4095];

  alu_resp_tx #(.CLKS_PER_BIT(4)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .res_valid_i(res_valid),
    .res_ready_o(res_ready),
    .res_data_i(res_data),
    .echo_valid_i(echo_valid),
    .echo_ready_o(echo_ready),
    .echo_data_i(echo_data),
    .echo_last_i(echo_last),
    .tx_o(tx),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (n < 4096) begin
      tx_log[n] <= tx;
      bz_log[n] <= busy;
      er_log[n] <= echo_ready;
      rr_log[n] <= res_ready;
    end
    n <= n + 1;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  function automatic int cnt(int sel, int a, int b);
    int c = 0;
    for (int i = a; i <= b; i++) begin
      case (sel)
        0: c += int'(tx_log[i]);
        1: c += int'(bz_log[i]);
        2: c += int'(er_log[i]);
        default: c += int'(rr_log[i]);
      endcase
    end
    return c;
  endfunction

  task automatic check_frame(string tag, int s, logic [7:0] d);
    logic [10:0] e, w0, w3;
    e = '1;
    e[0] = 1'b0;
    e[8:1] = d;
    if (FB == 11) e[9] = ^d;
    w0 = '1;
    w3 = '1;
    for (int i = 0; i < FB; i++) begin
      w0[i] = tx_log[s + 4 * i];
      w3[i] = tx_log[s + 4 * i + 3];
    end
    chk(tag, {w0, w3}, {e, e});
  endtask

  task automatic send_result(string tag, logic [31:0] d);
    int b;
    b = n;
    res_valid = 1'b1;
    res_data = d;
    cyc(1);
    res_valid = 1'b0;
    cyc(4 * FC + 4);
    chk({tag, " pre"}, tx_log[b], 1);
    for (int f = 0; f < 4; f++)
      check_frame($sformatf("%s byte%0d", tag, f), b + 1 + f * FC, d[8*f +: 8]);
    chk({tag, " busy len"}, cnt(1, b, b + 4 * FC + 3), 4 * FC);
    chk({tag, " busy end"}, {bz_log[b + 4 * FC], bz_log[b + 4 * FC + 1]}, 2'b10);
  endtask

  initial begin
    int b;
    // reset state
    cyc(2);
    chk("rst tx", tx, 1);
    chk("rst busy", busy, 0);
    chk("rst res_ready", res_ready, 1);
    chk("rst echo_ready", echo_ready, 1);
    res_valid = 1'b1;
    #1;
    chk("rst echo_ready resv", echo_ready, 0);
    cyc(1);
    res_valid = 1'b0;
    rst_n = 1'b1;
    cyc(2);

    send_result("res12345678", 32'h1234_5678);

    // echo AB then CD(last) with valid held
    b = n;
    echo_valid = 1'b1;
    echo_data = 8'hAB;
    echo_last = 1'b0;
    cyc(1);
    echo_data = 8'hCD;
    echo_last = 1'b1;
    cyc(FC + 1);
    echo_valid = 1'b0;
    echo_last = 1'b0;
    cyc(FC + 4);
    check_frame("echo AB", b + 1, 8'hAB);
    check_frame("echo CD", b + 1 + FC, 8'hCD);
    chk("echo rdy pulses", cnt(2, b + 1, b + 2 * FC), 1);
    chk("echo rdy at stop", er_log[b + FC], 1);
    chk("echo idle after", {bz_log[b + 2 * FC + 1], rr_log[b + 2 * FC + 1]}, 2'b01);

    // result has priority over echo
    b = n;
    res_valid = 1'b1;
    res_data = 32'h0000_00FF;
    echo_valid = 1'b1;
    echo_data = 8'h11;
    echo_last = 1'b1;
    cyc(1);
    res_valid = 1'b0;
    cyc(4 * FC + 2);
    echo_valid = 1'b0;
    echo_last = 1'b0;
    cyc(FC + 4);
    check_frame("prio FF", b + 1, 8'hFF);
    check_frame("prio 00a", b + 1 + FC, 8'h00);
    check_frame("prio 00c", b + 1 + 3 * FC, 8'h00);
    chk("prio echo blocked", cnt(2, b, b + 4 * FC), 0);
    chk("prio echo rdy idle", er_log[b + 4 * FC + 1], 1);
    check_frame("prio 11", b + 4 * FC + 2, 8'h11);
    chk("prio idle after", bz_log[b + 5 * FC + 2], 0);

    // echo 5A, source stalls 20 cycles, then 3C(last)
    b = n;
    echo_valid = 1'b1;
    echo_data = 8'h5A;
    echo_last = 1'b0;
    cyc(1);
    echo_valid = 1'b0;
    res_valid = 1'b1;
    res_data = 32'hDEAD_BEEF;
    cyc(FC + 20);
    res_valid = 1'b0;
    echo_valid = 1'b1;
    echo_data = 8'h3C;
    echo_last = 1'b1;
    cyc(1);
    echo_valid = 1'b0;
    echo_last = 1'b0;
    cyc(FC + 4);
    check_frame("wait 5A", b + 1, 8'h5A);
    chk("wait tx high", cnt(0, b + FC + 1, b + FC + 20), 20);
    chk("wait echo rdy", cnt(2, b + FC + 1, b + FC + 20), 20);
    chk("wait res rdy", cnt(3, b + FC + 1, b + FC + 21), 0);
    check_frame("wait 3C", b + FC + 22, 8'h3C);

    // reset during data bit 3
    res_valid = 1'b1;
    res_data = 32'h1234_5670;
    cyc(1);
    res_valid = 1'b0;
    cyc(17);
    chk("mid tx bit3", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("mid rst tx", tx, 1);
    chk("mid rst busy", busy, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    send_result("resA5A5A5A5", 32'hA5A5_A5A5);

    send_result("res00000178", 32'h0000_0178);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_resp_tx.md
# alu_resp_tx

Response transmitter for the UART ALU. It takes either a 32-bit ALU result or a stream of echo bytes from the packet parser/ALU side. It serializes the response onto the UART TX line as 8N1 frames, producing the byte stream the host decodes: 4 result bytes LSB first, or the echo payload bytes in order. It is the transmit-side counterpart of the command receiver/parser and owns the baud timing on the TX pin.

## Interface

Parameters:
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.

Ports:
- clk_i  in  1  system clock; the block uses this single clock.
- rst_ni  in  1  reset, asynchronous and active-low.
- res_valid_i  in  1  ALU result available.
- res_ready_o  out  1  result accepted when res_valid_i && res_ready_o.
- res_data_i  in  32  ALU result.
- echo_valid_i  in  1  echo byte available.
- echo_ready_o  out  1  echo byte accepted when echo_valid_i && echo_ready_o.
- echo_data_i  in  8  echo byte.
- echo_last_i  in  1  qualifies the accepted echo byte as the final byte of the packet.
- tx_o  out  1  UART serial output, idle high.
- busy_o  out  1  high from acceptance of a packet until the last stop bit completes.

## Operation

- Packet FSM states:
  - IDLE
  - RES: 4 bytes, index 0..3.
  - ECHO_SEND
  - ECHO_WAIT
- Bit FSM states:
  - START
  - DATA: 8 bits, LSB first.
  - PARITY: only with the configuration macro.
  - STOP
- IDLE behaviour:
  - res_ready_o=1.
  - echo_ready_o = !res_valid_i.
  - Result has priority when both valids are high in the same cycle.
- Result accept:
  - The block latches res_data_i into a 32-bit shift register.
  - It sends byte0 = [7:0], then [15:8], [23:16], [31:24].
  - It returns to IDLE after the 4th stop bit.
- Echo accept:
  - The block latches the byte and its last flag, then sends it.
  - At the last stop-bit cycle of a non-last byte, echo_ready_o=1.
  - If the handshake completes in that cycle, the next START follows with no gap.
  - Otherwise the FSM enters ECHO_WAIT: tx_o=1, echo_ready_o=1, res_ready_o=0 until the next echo byte arrives.
  - After the stop bit of a last byte, the FSM returns to IDLE.
- A packet is never interrupted. res_ready_o=0 in every state except IDLE, including ECHO_WAIT.
- echo_ready_o=0 in RES and in all bit states except the final STOP cycle of a non-last echo byte.
- Baud counter:
  - Loads CLKS_PER_BIT-1 at each bit start.
  - The bit advances when the counter reaches 0.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
- Reset values: tx_o=1, busy_o=0, FSMs in IDLE, counters 0. Consequently res_ready_o=1 and echo_ready_o=!res_valid_i while in reset.
- Reset asserted mid-frame: tx_o returns to 1 asynchronously and the partial packet is discarded.

## Timing

- Handshake to start bit: the start bit appears on tx_o in the cycle after the accepting edge (registered output).
- Frame length: 10·CLKS_PER_BIT cycles, or 11 with parity.
- Result packet length: 4 frames back-to-back, 40·CLKS_PER_BIT cycles from first start bit to end of last stop bit.
- busy_o rises with tx_o's first start bit and falls in the cycle after the final stop bit ends.
- Back-to-back packets: a new result can be accepted in the first IDLE cycle, with no extra idle bit beyond the stop bit.
- tx_o is driven directly from a flop; it is glitch-free.

## Configuration

- UART_TX_PARITY_EN defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and the stop bit.
  - Frames become 11 bits (8E1).
- UART_TX_PARITY_EN undefined: 8N1, 10-bit frames, and no parity logic is present.

## Test plan

All scenarios use CLKS_PER_BIT=4.

- Result 0x12345678:
  - tx_o carries bytes 0x78, 0x56, 0x34, 0x12, each start=0 / 8 data LSB-first / stop=1, 4 cycles per bit.
  - The packet lasts 160 cycles; busy_o falls after.
- Echo 0xAB, then 0xCD with last=1, valid held:
  - Two contiguous frames, no gap.
  - echo_ready_o pulses exactly once, in the final stop cycle of 0xAB.
  - After the packet, the FSM is in IDLE.
- res_valid_i and echo_valid_i high together in IDLE with result 0x000000FF and echo 0x11:
  - The result is sent first: 0xFF, 00, 00, 00.
  - echo_ready_o stays 0 until IDLE, then 0x11 is accepted.
- Echo 0x5A (not last), then echo_valid_i low for 20 cycles:
  - tx_o stays 1 for those 20 cycles; echo_ready_o=1 and res_ready_o=0 throughout, even with res_valid_i=1.
  - 0x3C with last=1 then transmits.
- Reset mid-frame: assert rst_ni=0 during DATA bit 3 of a result.
  - tx_o=1 and busy_o=0 immediately.
  - After release, result 0xA5A5A5A5 transmits correctly.
- With UART_TX_PARITY_EN: result 0x00000178.
  - Parity bits are 0 for 0x78, 1 for 0x01, 0 for 0x00 and 0x00.
  - Frames are 44 cycles each.
